// File: rtl/divmmc_pkg.sv
// rtl/divmmc_pkg.sv - DivMMC port constants and bus front-end state encoding
package divmmc_pkg;

  localparam logic [7:0] DIVMMC_PORT_CTRL = 8'hE3;
  localparam logic [7:0] DIVMMC_PORT_CS   = 8'hE7;
  localparam logic [7:0] DIVMMC_PORT_SPI  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    STALL,
    FIRE,
    HOLD
  } divmmc_state_e;

endpackage

// File: rtl/divmmc_sync_ff.sv
// rtl/divmmc_sync_ff.sv - N-stage synchroniser for an async active-low strobe, resets to idle (1)
module divmmc_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/divmmc_bus_sync.sv
// rtl/divmmc_bus_sync.sv - Z80 I/O bus front end: strobe sync, DivMMC port qualification, WAIT stretch
module divmmc_bus_sync
  import divmmc_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PORT_CTRL   = DIVMMC_PORT_CTRL,
  parameter logic [7:0] PORT_CS     = DIVMMC_PORT_CS,
  parameter logic [7:0] PORT_SPI    = DIVMMC_PORT_SPI,
  parameter int         WAIT_MAX    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] a,
  input  logic [7:0] din,
  input  logic       spi_busy,
  output logic       cpu_wait_n,
  output logic       ctrl_we,
  output logic       cs_we,
  output logic       spi_tx_go,
  output logic       spi_rx_go,
  output logic [7:0] wdata,
  output logic       wait_tmo
);

  localparam int CNT_W = $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  logic iorq_s, rd_s, wr_s;

  divmmc_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_iorq (
    .clk(clk), .rst(rst), .d_i(iorq_n), .q_o(iorq_s)
  );
  divmmc_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst), .d_i(rd_n), .q_o(rd_s)
  );
  divmmc_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst), .d_i(wr_n), .q_o(wr_s)
  );

  divmmc_state_e    state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_n_q, wait_n_d;
  logic             ctrl_we_q, ctrl_we_d;
  logic             cs_we_q, cs_we_d;
  logic             tx_go_q, tx_go_d;
  logic             rx_go_q, rx_go_d;
  logic             tmo_q, tmo_d;
  logic             port_hit;

  assign port_hit = (a == PORT_CTRL) || (a == PORT_CS) || (a == PORT_SPI);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    wait_n_d  = wait_n_q;
    ctrl_we_d = 1'b0;
    cs_we_d   = 1'b0;
    tx_go_d   = 1'b0;
    rx_go_d   = 1'b0;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE: begin
        if (!iorq_s) begin
          if (!rd_s && !wr_s) begin
            state_d = HOLD;
          end else if (!rd_s || !wr_s) begin
            state_d = QUAL;
          end
        end
      end

      QUAL: begin
        if (iorq_s || (rd_s && wr_s)) begin
          state_d = IDLE;
        end else if (!rd_s && !wr_s) begin
          state_d = HOLD;
        end else begin
          addr_d  = a;
          wdata_d = din;
          is_wr_d = !wr_s;
          if (!port_hit) begin
            state_d = HOLD;
          end else if ((a == PORT_SPI) && spi_busy) begin
            state_d  = STALL;
            wait_n_d = 1'b0;
            cnt_d    = '0;
          end else begin
            state_d = FIRE;
          end
        end
      end

      // Abort beats busy release, which beats timeout.
      STALL: begin
        if (iorq_s) begin
          state_d  = IDLE;
          wait_n_d = 1'b1;
        end else if (!spi_busy) begin
          state_d  = FIRE;
          wait_n_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = FIRE;
          wait_n_d = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIRE: begin
        if (addr_q == PORT_CTRL) begin
          ctrl_we_d = is_wr_q;
        end else if (addr_q == PORT_CS) begin
          cs_we_d = is_wr_q;
        end else if (addr_q == PORT_SPI) begin
          tx_go_d = is_wr_q;
          rx_go_d = !is_wr_q;
        end
        state_d = HOLD;
      end

      HOLD: begin
        if (iorq_s && rd_s && wr_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      wait_n_q  <= 1'b1;
      ctrl_we_q <= 1'b0;
      cs_we_q   <= 1'b0;
      tx_go_q   <= 1'b0;
      rx_go_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      wait_n_q  <= wait_n_d;
      ctrl_we_q <= ctrl_we_d;
      cs_we_q   <= cs_we_d;
      tx_go_q   <= tx_go_d;
      rx_go_q   <= rx_go_d;
      tmo_q     <= tmo_d;
    end
  end

  assign cpu_wait_n = wait_n_q;
  assign ctrl_we    = ctrl_we_q;
  assign cs_we      = cs_we_q;
  assign spi_tx_go  = tx_go_q;
  assign spi_rx_go  = rx_go_q;
  assign wdata      = wdata_q;
  assign wait_tmo   = tmo_q;

endmodule

// File: tb/tb_divmmc_bus_sync.sv
// tb/tb_divmmc_bus_sync.sv - directed bench for divmmc_bus_sync
module tb_divmmc_bus_sync;
  import divmmc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] din = 8'h00;
  logic       spi_busy = 1'b0;
  logic       cpu_wait_n, ctrl_we, cs_we, spi_tx_go, spi_rx_go, wait_tmo;
  logic [7:0] wdata;

  int n_cmp = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_ctrl = 0, n_cs = 0, n_tx = 0, n_rx = 0, n_multi = 0, n_wlow = 0;
  int last_wlow_cyc = 0, last_tx_cyc = 0;
  logic [7:0] last_wdata = 8'h00;

  divmmc_bus_sync #(
    .SYNC_STAGES(2), .PORT_CTRL(8'hE3), .PORT_CS(8'hE7), .PORT_SPI(8'hEB), .WAIT_MAX(32)
  ) dut (
    .clk(clk), .rst(rst), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .a(a), .din(din), .spi_busy(spi_busy), .cpu_wait_n(cpu_wait_n),
    .ctrl_we(ctrl_we), .cs_we(cs_we), .spi_tx_go(spi_tx_go), .spi_rx_go(spi_rx_go),
    .wdata(wdata), .wait_tmo(wait_tmo)
  );

  always #5 clk = ~clk;

  // Strobe/WAIT monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (ctrl_we) begin n_ctrl <= n_ctrl + 1; last_wdata <= wdata; end
      if (cs_we) begin n_cs <= n_cs + 1; last_wdata <= wdata; end
      if (spi_tx_go) begin n_tx <= n_tx + 1; last_wdata <= wdata; last_tx_cyc <= cyc; end
      if (spi_rx_go) n_rx <= n_rx + 1;
      if (int'(ctrl_we) + int'(cs_we) + int'(spi_tx_go) + int'(spi_rx_go) > 1) n_multi <= n_multi + 1;
      if (!cpu_wait_n) begin n_wlow <= n_wlow + 1; last_wlow_cyc <= cyc; end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_cycle(input logic is_wr, input logic [7:0] addr, input logic [7:0] data,
                           input int hold, input logic obey_wait);
    int guard;
    @(negedge clk);
    a = addr;
    din = data;
    iorq_n = 1'b0;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    for (int i = 0; i < hold; i++) @(negedge clk);
    guard = 0;
    while (obey_wait && !cpu_wait_n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_bound: cpu_wait_n still %b after %0d cycles, required release", cpu_wait_n, guard);
    end
    iorq_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    idle(6);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL reset_wait: got %b want 1", cpu_wait_n); end
    n_cmp++; if ({ctrl_we, cs_we, spi_tx_go, spi_rx_go} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {ctrl_we, cs_we, spi_tx_go, spi_rx_go}); end
    n_cmp++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", wdata); end
    n_cmp++; if (wait_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", wait_tmo); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_ctrl_write;
    int c0, w0, lat;
    c0 = n_ctrl; w0 = n_wlow;
    @(negedge clk);
    a = 8'hE3; din = 8'h83; iorq_n = 1'b0; wr_n = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ctrl_we && lat < 20);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL ctrl_latency: got %0d edges want 5", lat); end
    idle(4);
    iorq_n = 1'b1; wr_n = 1'b1;
    idle(6);
    n_cmp++; if (n_ctrl - c0 !== 1) begin n_fail++; $display("FAIL ctrl_count: got %0d want 1", n_ctrl - c0); end
    n_cmp++; if (last_wdata !== 8'h83) begin n_fail++; $display("FAIL ctrl_wdata: got %h want 83", last_wdata); end
    n_cmp++; if (n_wlow - w0 !== 0) begin n_fail++; $display("FAIL ctrl_wait: got %0d low cycles want 0", n_wlow - w0); end
  endtask

  // Drop spi_busy after WAIT has been low for 'low' sampled cycles.
  task automatic spi_busy_write(input int low, input logic [7:0] data, input logic exp_tmo, input string tag);
    int t0, w0, g;
    t0 = n_tx; w0 = n_wlow;
    spi_busy = 1'b1;
    fork
      bus_cycle(1'b1, 8'hEB, data, 6, 1'b1);
      begin
        g = 0;
        do begin @(negedge clk); g++; end while (cpu_wait_n && g < 30);
        for (int i = 1; i < low; i++) @(negedge clk);
        spi_busy = 1'b0;
      end
    join
    n_cmp++; if (n_wlow - w0 !== low) begin n_fail++; $display("FAIL %s_wait_low: got %0d want %0d", tag, n_wlow - w0, low); end
    n_cmp++; if (n_tx - t0 !== 1) begin n_fail++; $display("FAIL %s_tx_count: got %0d want 1", tag, n_tx - t0); end
    n_cmp++; if (last_tx_cyc - last_wlow_cyc !== 2) begin
      n_fail++; $display("FAIL %s_tx_timing: got %0d want 2", tag, last_tx_cyc - last_wlow_cyc); end
    n_cmp++; if (last_wdata !== data) begin n_fail++; $display("FAIL %s_wdata: got %h want %h", tag, last_wdata, data); end
    n_cmp++; if (wait_tmo !== exp_tmo) begin n_fail++; $display("FAIL %s_tmo: got %b want %b", tag, wait_tmo, exp_tmo); end
  endtask

  task automatic test_timeout;
    int r0, w0;
    r0 = n_rx; w0 = n_wlow;
    spi_busy = 1'b1;
    bus_cycle(1'b0, 8'hEB, 8'h00, 6, 1'b1);
    spi_busy = 1'b0;
    n_cmp++; if (n_wlow - w0 !== 32) begin n_fail++; $display("FAIL tmo_wait_low: got %0d want 32", n_wlow - w0); end
    n_cmp++; if (n_rx - r0 !== 1) begin n_fail++; $display("FAIL tmo_rx_count: got %0d want 1", n_rx - r0); end
    n_cmp++; if (wait_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", wait_tmo); end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = n_ctrl + n_cs + n_tx + n_rx;
    @(negedge clk);
    a = 8'hE3; din = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    idle(8);
    n_cmp++; if (n_ctrl + n_cs + n_tx + n_rx - s0 !== 0) begin
      n_fail++; $display("FAIL glitch_strobes: got %0d want 0", n_ctrl + n_cs + n_tx + n_rx - s0); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_no_strobe;
    int s0, c0;
    s0 = n_ctrl + n_cs + n_tx + n_rx;
    bus_cycle(1'b1, 8'hFE, 8'h07, 8, 1'b0);
    bus_cycle(1'b0, 8'hE7, 8'h00, 8, 1'b0);
    bus_cycle(1'b0, 8'hE3, 8'h00, 8, 1'b0);
    @(negedge clk);
    a = 8'hE3; din = 8'h22; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    idle(8);
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    idle(6);
    n_cmp++; if (n_ctrl + n_cs + n_tx + n_rx - s0 !== 0) begin
      n_fail++; $display("FAIL nohit_strobes: got %0d want 0", n_ctrl + n_cs + n_tx + n_rx - s0); end
    c0 = n_cs;
    bus_cycle(1'b1, 8'hE7, 8'h01, 200, 1'b0);
    n_cmp++; if (n_cs - c0 !== 1) begin n_fail++; $display("FAIL long_cs_count: got %0d want 1", n_cs - c0); end
    n_cmp++; if (last_wdata !== 8'h01) begin n_fail++; $display("FAIL long_cs_wdata: got %h want 01", last_wdata); end
  endtask

  task automatic test_back_to_back;
    int c0, s0, r0;
    c0 = n_ctrl; s0 = n_cs; r0 = n_rx;
    bus_cycle(1'b1, 8'hE7, 8'hFE, 6, 1'b1);
    n_cmp++; if (last_wdata !== 8'hFE) begin n_fail++; $display("FAIL b2b_cs_wdata: got %h want fe", last_wdata); end
    bus_cycle(1'b1, 8'hE3, 8'hC0, 6, 1'b1);
    n_cmp++; if (last_wdata !== 8'hC0) begin n_fail++; $display("FAIL b2b_ctrl_wdata: got %h want c0", last_wdata); end
    bus_cycle(1'b0, 8'hEB, 8'h00, 6, 1'b1);
    n_cmp++; if ({n_ctrl - c0, n_cs - s0, n_rx - r0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL b2b_counts: got ctrl=%0d cs=%0d rx=%0d want 1/1/1", n_ctrl - c0, n_cs - s0, n_rx - r0); end
    n_cmp++; if (n_multi !== 0) begin n_fail++; $display("FAIL multi_strobe: got %0d want 0", n_multi); end
    n_cmp++; if (wait_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", wait_tmo); end
  endtask

  task automatic test_abort;
    int t0, w0;
    t0 = n_tx; w0 = n_wlow;
    spi_busy = 1'b1;
    bus_cycle(1'b1, 8'hEB, 8'h33, 6, 1'b0);
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL abort_wait: got %b want 1", cpu_wait_n); end
    n_cmp++; if (n_tx - t0 !== 0) begin n_fail++; $display("FAIL abort_tx: got %0d want 0", n_tx - t0); end
    n_cmp++; if (n_wlow - w0 !== 5) begin n_fail++; $display("FAIL abort_wait_low: got %0d want 5", n_wlow - w0); end
    spi_busy = 1'b0;
    idle(2);
  endtask

  task automatic test_rst_in_stall;
    int t0, g;
    t0 = n_tx;
    spi_busy = 1'b1;
    @(negedge clk);
    a = 8'hEB; din = 8'h44; iorq_n = 1'b0; wr_n = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (cpu_wait_n && g < 20);
    n_cmp++; if (cpu_wait_n !== 1'b0) begin n_fail++; $display("FAIL rst_stall_entry: got %b want 0", cpu_wait_n); end
    idle(3);
    rst = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL rst_stall_wait: got %b want 1", cpu_wait_n); end
    n_cmp++; if (wait_tmo !== 1'b0) begin n_fail++; $display("FAIL rst_stall_tmo: got %b want 0", wait_tmo); end
    rst = 1'b0; spi_busy = 1'b0;
    idle(8);
    n_cmp++; if (n_tx - t0 !== 0) begin n_fail++; $display("FAIL rst_stall_tx: got %0d want 0", n_tx - t0); end
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    spi_busy_write(10, 8'h5A, 1'b0, "busy10");
    spi_busy_write(32, 8'hA5, 1'b0, "release_at_tmo");
    test_timeout();
    test_glitch();
    test_no_strobe();
    test_back_to_back();
    test_abort();
    test_rst_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
